// File: rtl/if_stage_pkg.sv
// Shared pipeline package: fetch FSM encoding and the bubble word.
// Decode imports this so that both stages agree on what a NOP looks like.
package if_stage_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } if_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, req/ack fetch FSM, one-entry skid buffer,
// redirect handling with a pending target, and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int PC_WIDTH = 6,
    parameter int INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR =
        INSTR_WIDTH'(if_stage_pkg::NOP_INSTR)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] Instruction,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   valid_out
);

    if_state_e state, state_nxt;

    logic [PC_WIDTH-1:0]    pc, pc_nxt;
    logic [PC_WIDTH-1:0]    pend, pend_nxt;
    logic [INSTR_WIDTH-1:0] skid, skid_nxt;
    logic [INSTR_WIDTH-1:0] instr_nxt;
    logic [PC_WIDTH-1:0]    pc_out_nxt;
    logic                   valid_nxt;
    logic                   xfer;

    assign imem_req  = (state == FETCH) || (state == DISCARD);
    assign imem_addr = pc;
    assign xfer      = imem_req & imem_ack;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        pend_nxt   = pend;
        skid_nxt   = skid;
        instr_nxt  = Instruction;
        pc_out_nxt = pc_out;
        valid_nxt  = valid_out;
        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end
            end
            FETCH: begin
                if (redirect) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                    if (xfer) begin
                        pc_nxt = redirect_pc;
                    end else begin
                        // request to old address must still complete
                        pend_nxt  = redirect_pc;
                        state_nxt = DISCARD;
                    end
                end else if (xfer) begin
                    if (stall) begin
                        skid_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end else begin
                        instr_nxt  = imem_rdata;
                        pc_out_nxt = pc;
                        valid_nxt  = 1'b1;
                        pc_nxt     = pc + PC_WIDTH'(1);
                    end
                end else if (!stall) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pend_nxt = redirect_pc;
                end
                if (redirect || !stall) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end
                if (xfer) begin
                    pc_nxt    = redirect ? redirect_pc : pend;
                    state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    instr_nxt  = skid;
                    pc_out_nxt = pc;
                    valid_nxt  = 1'b1;
                    pc_nxt     = pc + PC_WIDTH'(1);
                    state_nxt  = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= '0;
            pend        <= '0;
            skid        <= '0;
            Instruction <= NOP_INSTR;
            pc_out      <= '0;
            valid_out   <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend        <= pend_nxt;
            skid        <= skid_nxt;
            Instruction <= instr_nxt;
            pc_out      <= pc_out_nxt;
            valid_out   <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table, hand sequences and
// an in-order scoreboard of accepted instructions.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [5:0]  redirect_pc = '0;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [5:0]  pc_out;
    logic        valid_out;

    int checks = 0;
    int failures = 0;
    int delay = 0;
    int cnt = 0;
    logic force_ack = 1'b0;
    logic sb_on = 1'b0;
    logic [5:0] sb_q[$];

    typedef struct {
        logic       stall;
        logic       redir;
        logic [5:0] rpc;
        int         dly;
        logic       ereq;
        logic [5:0] eaddr;
        logic       evalid;
        logic [5:0] epc;
    } vec_t;

    vec_t tbl[15];

    if_stage dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .Instruction(Instruction),
        .pc_out(pc_out),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [5:0] a);
        return {16'hC0DE, 10'd0, a};
    endfunction

    function automatic vec_t mk(input int s, input int r, input int rp,
                                input int d, input int q, input int a,
                                input int v, input int p);
        vec_t x;
        x.stall = 1'(s);
        x.redir = 1'(r);
        x.rpc = 6'(rp);
        x.dly = d;
        x.ereq = 1'(q);
        x.eaddr = 6'(a);
        x.evalid = 1'(v);
        x.epc = 6'(p);
        return x;
    endfunction

    // memory: ack after 'delay' wait cycles of a live request
    assign imem_ack = (imem_req && (cnt >= delay)) || force_ack;
    assign imem_rdata = memw(imem_addr);

    always @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 0;
        else if (imem_req && !imem_ack) cnt <= cnt + 1;
        else cnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // decode consumes IF/ID when valid and not stalled
    always @(negedge clk) begin
        if (sb_on && rst && valid_out && !stall) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra actual=%0d required=none", pc_out);
            end else begin
                logic [5:0] e;
                e = sb_q.pop_front();
                chk("sb_pc", {26'd0, pc_out}, {26'd0, e});
                chk("sb_instr", Instruction, memw(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        force_ack = 1'b0;
        sb_on = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_pc", {26'd0, pc_out}, 32'd0);
        chk("rst_instr", Instruction, NOP);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", {26'd0, imem_addr}, 32'd0);
    endtask

    task automatic end_scn(input string nm);
        stall = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        #1;
        sb_on = 1'b0;
        chk({nm, "_sb_left"}, sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // zero-wait run, 3-cycle ack at PC 5, redirect to 20 at PC 7
        tbl[0]  = mk(0, 0, 0,  0, 1, 1,  1, 0);
        tbl[1]  = mk(0, 0, 0,  0, 1, 2,  1, 1);
        tbl[2]  = mk(0, 0, 0,  0, 1, 3,  1, 2);
        tbl[3]  = mk(0, 0, 0,  0, 1, 4,  1, 3);
        tbl[4]  = mk(0, 0, 0,  0, 1, 5,  1, 4);
        tbl[5]  = mk(0, 0, 0,  3, 1, 5,  0, 4);
        tbl[6]  = mk(0, 0, 0,  3, 1, 5,  0, 4);
        tbl[7]  = mk(0, 0, 0,  3, 1, 5,  0, 4);
        tbl[8]  = mk(0, 0, 0,  3, 1, 6,  1, 5);
        tbl[9]  = mk(0, 0, 0,  0, 1, 7,  1, 6);
        tbl[10] = mk(0, 1, 20, 3, 1, 7,  0, 6);
        tbl[11] = mk(0, 0, 0,  3, 1, 7,  0, 6);
        tbl[12] = mk(0, 0, 0,  3, 1, 7,  0, 6);
        tbl[13] = mk(0, 0, 0,  3, 1, 20, 0, 6);
        tbl[14] = mk(0, 0, 0,  0, 1, 21, 1, 20);

        delay = 0;
        do_reset();
        sb_on = 1'b1;
        for (int i = 0; i < 15; i++) begin
            stall = tbl[i].stall;
            redirect = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            delay = tbl[i].dly;
            if (tbl[i].evalid) sb_q.push_back(tbl[i].epc);
            step();
            chk($sformatf("v%0d_req", i), {31'd0, imem_req},
                {31'd0, tbl[i].ereq});
            chk($sformatf("v%0d_addr", i), {26'd0, imem_addr},
                {26'd0, tbl[i].eaddr});
            chk($sformatf("v%0d_valid", i), {31'd0, valid_out},
                {31'd0, tbl[i].evalid});
            chk($sformatf("v%0d_pc", i), {26'd0, pc_out},
                {26'd0, tbl[i].epc});
            chk($sformatf("v%0d_instr", i), Instruction,
                tbl[i].evalid ? memw(tbl[i].epc) : NOP);
        end
        redirect = 1'b0;
        delay = 0;
        end_scn("table");

        // stall 4 cycles while PC 2 is acked; stray ack while idle
        delay = 0;
        do_reset();
        for (int i = 0; i < 4; i++) sb_q.push_back(6'(i));
        sb_on = 1'b1;
        step();
        chk("st_pc0", {26'd0, pc_out}, 32'd0);
        step();
        chk("st_pc1", {26'd0, pc_out}, 32'd1);
        chk("st_addr2", {26'd0, imem_addr}, 32'd2);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            force_ack = (i == 1);
            step();
            chk($sformatf("st_hold%0d_req", i), {31'd0, imem_req}, 32'd0);
            chk($sformatf("st_hold%0d_pc", i), {26'd0, pc_out}, 32'd1);
            chk($sformatf("st_hold%0d_valid", i), {31'd0, valid_out}, 32'd1);
            chk($sformatf("st_hold%0d_addr", i), {26'd0, imem_addr}, 32'd2);
        end
        force_ack = 1'b0;
        stall = 1'b0;
        step();
        chk("st_rel_pc", {26'd0, pc_out}, 32'd2);
        chk("st_rel_instr", Instruction, memw(6'd2));
        chk("st_rel_req", {31'd0, imem_req}, 32'd1);
        chk("st_rel_addr", {26'd0, imem_addr}, 32'd3);
        step();
        chk("st_next_pc", {26'd0, pc_out}, 32'd3);
        end_scn("stall");

        // wrap from the top address back to 0
        delay = 0;
        do_reset();
        sb_q.push_back(6'd62);
        sb_q.push_back(6'd63);
        sb_q.push_back(6'd0);
        sb_on = 1'b1;
        redirect = 1'b1;
        redirect_pc = 6'd62;
        step();
        redirect = 1'b0;
        chk("wr_valid", {31'd0, valid_out}, 32'd0);
        chk("wr_addr62", {26'd0, imem_addr}, 32'd62);
        step();
        chk("wr_pc62", {26'd0, pc_out}, 32'd62);
        step();
        chk("wr_pc63", {26'd0, pc_out}, 32'd63);
        chk("wr_addr0", {26'd0, imem_addr}, 32'd0);
        step();
        chk("wr_pc0", {26'd0, pc_out}, 32'd0);
        chk("wr_instr0", Instruction, memw(6'd0));
        end_scn("wrap");

        // reset asserted while a discarded fetch is outstanding
        delay = 5;
        do_reset();
        redirect = 1'b1;
        redirect_pc = 6'd9;
        step();
        redirect = 1'b0;
        chk("rd_req", {31'd0, imem_req}, 32'd1);
        chk("rd_addr", {26'd0, imem_addr}, 32'd0);
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("rd_async_req", {31'd0, imem_req}, 32'd0);
        chk("rd_async_valid", {31'd0, valid_out}, 32'd0);
        chk("rd_async_pc", {26'd0, pc_out}, 32'd0);
        delay = 0;
        do_reset();
        sb_q.push_back(6'd0);
        sb_q.push_back(6'd1);
        sb_on = 1'b1;
        step();
        chk("rd_pc0", {26'd0, pc_out}, 32'd0);
        chk("rd_valid0", {31'd0, valid_out}, 32'd1);
        step();
        chk("rd_pc1", {26'd0, pc_out}, 32'd1);
        end_scn("rstdisc");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 6, meaning word-address width of PC and imem_addr.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, meaning instruction word width.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0000, meaning bubble word driven when no valid instruction is present.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, asynchronous, active-low.
REQ-006 SHALL have port stall  input  1  meaning decode cannot accept; hold IF/ID register.
REQ-007 SHALL have port redirect  input  1  meaning taken branch or flush; fetch restarts at redirect_pc.
REQ-008 SHALL have port redirect_pc  input  PC_WIDTH  meaning redirect word address.
REQ-009 SHALL have port imem_req  output  1  meaning fetch request to instruction memory.
REQ-010 SHALL have port imem_addr  output  PC_WIDTH  meaning fetch word address.
REQ-011 SHALL have port imem_ack  input  1  meaning memory returns imem_rdata this cycle.
REQ-012 SHALL have port imem_rdata  input  INSTR_WIDTH  meaning fetched word, valid only when imem_ack=1.
REQ-013 SHALL have port Instruction  output  INSTR_WIDTH  meaning IF/ID instruction to decode.
REQ-014 SHALL have port pc_out  output  PC_WIDTH  meaning address of Instruction.
REQ-015 SHALL have port valid_out  output  1  meaning Instruction is real, not a bubble.

Function
REQ-016 SHALL implement states IDLE, FETCH, DISCARD, HOLD; imem_req=1 in FETCH and DISCARD only.
REQ-017 SHALL, once imem_req rises, hold imem_req high and imem_addr stable until the cycle with imem_ack=1 (transfer = req&ack); ack with req low is ignored.
REQ-018 SHALL drive imem_addr from the PC register; PC increments by 1 per accepted instruction, wrapping 2^PC_WIDTH-1 -> 0.
REQ-019 SHALL move IDLE -> FETCH unconditionally one cycle after reset release.
REQ-020 SHALL, in FETCH with ack, no redirect, no stall: load IF/ID with {imem_rdata, PC, valid=1}, PC<=PC+1, stay FETCH (back-to-back fetch; zero-wait memory gives one instruction per cycle).
REQ-021 SHALL, in FETCH with ack and stall, no redirect: capture imem_rdata into a one-entry skid register, keep IF/ID unchanged, go HOLD.
REQ-022 SHALL, in HOLD without redirect: when stall=0 load IF/ID from skid with valid=1, PC<=PC+1, go FETCH; else remain HOLD.
REQ-023 SHALL, in FETCH without ack and stall=0, load IF/ID with {NOP_INSTR, valid=0}; pc_out unchanged.
REQ-024 SHALL, on redirect in FETCH with ack or in HOLD, discard the fetched/skid word, PC<=redirect_pc, go FETCH.
REQ-025 SHALL, on redirect in FETCH without ack, latch redirect_pc into pending register and go DISCARD, keeping request to old address.
REQ-026 SHALL, in DISCARD, keep imem_req/addr; redirect overwrites pending (latest wins); on ack drop data, PC<=pending, go FETCH.
REQ-027 SHALL, on any redirect cycle, set IF/ID valid_out=0 and Instruction=NOP_INSTR next edge; redirect overrides stall.
REQ-028 SHALL never present the same PC with valid_out=1 in two separate acceptances without an intervening redirect.

Reset
REQ-029 SHALL, while rst=0, asynchronously force state=IDLE, PC=0, pending=0, skid=0, Instruction=NOP_INSTR, pc_out=0, valid_out=0, imem_req=0.
REQ-030 SHALL abandon any outstanding fetch on reset; first request after release is address 0.

Structure
REQ-031 SHALL place state encoding and NOP_INSTR in the shared pipeline package used by decode.
REQ-032 SHALL be one module with no sub-modules; PC/pending/skid/IF-ID registers and FSM inline.

Verification
REQ-033 SHALL test zero-wait memory, no stall: after reset, pc_out 0,1,2,3 on consecutive cycles with valid_out=1.
REQ-034 SHALL test ack delayed 3 cycles at PC=5: imem_addr=5 held 3 cycles, valid_out=0 meanwhile, then Instruction=mem[5].
REQ-035 SHALL test stall for 4 cycles during ack at PC=2: IF/ID holds PC 1, state HOLD, imem_req=0; release -> pc_out=2 with mem[2], no word lost or duplicated.
REQ-036 SHALL test redirect to 20 while waiting ack at PC=7: request for 7 completes and is dropped, next imem_addr=20, valid_out never shows PC 7.
REQ-037 SHALL test PC=2^PC_WIDTH-1 accepted: next imem_addr=0.
REQ-038 SHALL test rst asserted mid-DISCARD: imem_req and valid_out drop immediately; after release fetch restarts at 0.
